// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes the two coin sensors, debounces them and emits one coin code per insertion.
// Defining COIN_TOTAL_EN adds an 8-bit saturating running-total output.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sense5,
    input  logic       sense10,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam
`ifdef COIN_TOTAL_EN
    ,
    output logic [7:0] total
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        RELEASE,
        JAM
    } state_t;

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] JAM_LAST = 16'(JAM_CYCLES - 1);

    logic        s5Meta_q;
    logic        s5_q;
    logic        s10Meta_q;
    logic        s10_q;
    state_t      state_q;
    logic [15:0] cnt_q;
    logic        isTen_q;
    logic [1:0]  coin_q;
    logic        reject_q;
    logic        jam_q;
    logic        heldSensor;
    logic        otherSensor;
    logic        anyHigh;

    always_ff @(posedge clk) begin
        if (reset) begin
            s5Meta_q  <= 1'b0;
            s5_q      <= 1'b0;
            s10Meta_q <= 1'b0;
            s10_q     <= 1'b0;
        end else begin
            s5Meta_q  <= sense5;
            s5_q      <= s5Meta_q;
            s10Meta_q <= sense10;
            s10_q     <= s10Meta_q;
        end
    end

    // The sensor latched on leaving IDLE must stay high; the other one rising means an ambiguous coin.
    assign heldSensor  = isTen_q ? s10_q : s5_q;
    assign otherSensor = isTen_q ? s5_q : s10_q;
    assign anyHigh     = s5_q | s10_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            isTen_q  <= 1'b0;
            coin_q   <= 2'b00;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
        end else begin
            coin_q   <= 2'b00;
            reject_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    jam_q <= 1'b0;
                    if (s5_q && s10_q) begin
                        reject_q <= 1'b1;
                        state_q  <= RELEASE;
                        cnt_q    <= 16'd0;
                    end else if (s5_q ^ s10_q) begin
                        isTen_q <= s10_q;
                        state_q <= DEBOUNCE;
                        cnt_q   <= 16'd0;
                    end
                end
                DEBOUNCE: begin
                    if (!heldSensor) begin
                        state_q <= IDLE;
                        cnt_q   <= 16'd0;
                    end else if (otherSensor) begin
                        reject_q <= 1'b1;
                        state_q  <= RELEASE;
                        cnt_q    <= 16'd0;
                    end else if (cnt_q == DEB_LAST) begin
                        coin_q  <= isTen_q ? 2'b10 : 2'b01;
                        state_q <= EMIT;
                        cnt_q   <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                EMIT: begin
                    state_q <= RELEASE;
                    cnt_q   <= 16'd0;
                end
                RELEASE: begin
                    if (!anyHigh) begin
                        state_q <= IDLE;
                        cnt_q   <= 16'd0;
                    end else if (cnt_q == JAM_LAST) begin
                        jam_q   <= 1'b1;
                        state_q <= JAM;
                        cnt_q   <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                JAM: begin
                    if (!anyHigh) begin
                        jam_q   <= 1'b0;
                        state_q <= IDLE;
                        cnt_q   <= 16'd0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 16'd0;
                end
            endcase
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign jam    = jam_q;

`ifdef COIN_TOTAL_EN
    logic [7:0] total_q;
    logic [8:0] totalSum_d;

    // Nine-bit sum so overflow past 255 is visible and can be clamped.
    always_comb begin
        totalSum_d = {1'b0, total_q};
        case (coin_q)
            2'b01:   totalSum_d = {1'b0, total_q} + 9'd5;
            2'b10:   totalSum_d = {1'b0, total_q} + 9'd10;
            default: totalSum_d = {1'b0, total_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= 8'd0;
        end else begin
            total_q <= totalSum_d[8] ? 8'hFF : totalSum_d[7:0];
        end
    end

    assign total = total_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Testbench for coin_acceptor: coin insertions are planned as episodes whose expected outputs are
// derived arithmetically from their start edge, hold length and sensor overlap, then checked every cycle.
module tb_coin_acceptor;

    localparam int DEB  = 4;
    localparam int JAMC = 64;
    localparam int MAXE = 8192;

    logic       clk = 1'b0;
    logic       reset;
    logic       sense5;
    logic       sense10;
    logic [1:0] coin;
    logic       reject;
    logic       jam;
`ifdef COIN_TOTAL_EN
    logic [7:0] total;
    int         emit26;
`endif

    int nChecks = 0;
    int nBad = 0;
    int cursor = 1;
    int modelTotal = 0;

    bit       raw5  [0:MAXE-1];
    bit       raw10 [0:MAXE-1];
    bit [1:0] eCoin [0:MAXE-1];
    bit       eRej  [0:MAXE-1];
    bit       eJam  [0:MAXE-1];

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DEB),
        .JAM_CYCLES(JAMC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sense5(sense5),
        .sense10(sense10),
        .coin(coin),
        .reject(reject),
        .jam(jam)
`ifdef COIN_TOTAL_EN
        ,
        .total(total)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int edgeNo, input logic [7:0] obs, input logic [7:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nBad++;
            $error("[TB] FAIL %s at edge %0d: observed=%0d expected=%0d", tag, edgeNo, obs, exp);
        end
    endtask

    task automatic clearPlan();
        for (int t = 0; t < MAXE; t++) begin
            raw5[t]  = 1'b0;
            raw10[t] = 1'b0;
            eCoin[t] = 2'b00;
            eRej[t]  = 1'b0;
            eJam[t]  = 1'b0;
        end
        cursor = 1;
    endtask

    // Edge n samples raw[n]; the synchronized copy is first acted on at edge n+2.
    // kind 0: one sensor held len edges. kind 1: leader from e, other sensor joins d edges later, both drop together.
    task automatic applyStimulus(input int kind, input bit lead10, input int d, input int len, input int gap);
        int e;
        e = cursor;
        for (int t = e; t < e + len; t++) begin
            if (lead10) raw10[t] = 1'b1;
            else        raw5[t]  = 1'b1;
        end
        if (kind == 0) begin
            if (len >= DEB + 1) eCoin[e + 2 + DEB] = lead10 ? 2'b10 : 2'b01;
            for (int t = e + 3 + DEB + JAMC; t <= e + len + 1; t++) eJam[t] = 1'b1;
        end else begin
            for (int t = e + d; t < e + len; t++) begin
                if (lead10) raw5[t]  = 1'b1;
                else        raw10[t] = 1'b1;
            end
            eRej[e + d + 2] = 1'b1;
            for (int t = e + d + 2 + JAMC; t <= e + len + 1; t++) eJam[t] = 1'b1;
        end
        cursor = e + len + gap;
    endtask

    task automatic checkOutput(input int n);
        checkVal("coin", n, {6'd0, coin}, {6'd0, eCoin[n]});
        checkVal("reject", n, {7'd0, reject}, {7'd0, eRej[n]});
        checkVal("jam", n, {7'd0, jam}, {7'd0, eJam[n]});
`ifdef COIN_TOTAL_EN
        checkVal("total", n, total, 8'(modelTotal));
        if (eCoin[n] == 2'b01) modelTotal = (modelTotal + 5 > 255) ? 255 : modelTotal + 5;
        if (eCoin[n] == 2'b10) modelTotal = (modelTotal + 10 > 255) ? 255 : modelTotal + 10;
`endif
    endtask

    task automatic runPlan(input int first, input int last);
        for (int n = first; n <= last; n++) begin
            @(negedge clk);
            reset   = 1'b0;
            sense5  = raw5[n];
            sense10 = raw10[n];
            @(posedge clk);
            #1;
            checkOutput(n);
        end
    endtask

    // Leaves reset asserted; the next runPlan releases it so its edge 1 is the first edge out of reset.
    task automatic doReset(input bit h5, input bit h10);
        @(negedge clk);
        reset   = 1'b1;
        sense5  = h5;
        sense10 = h10;
        @(posedge clk);
        #1;
        checkVal("rst_coin", 0, {6'd0, coin}, 8'd0);
        checkVal("rst_reject", 0, {7'd0, reject}, 8'd0);
        checkVal("rst_jam", 0, {7'd0, jam}, 8'd0);
`ifdef COIN_TOTAL_EN
        checkVal("rst_total", 0, total, 8'd0);
`endif
        modelTotal = 0;
    endtask

    initial begin
        reset   = 1'b1;
        sense5  = 1'b0;
        sense10 = 1'b0;
        doReset(1'b0, 1'b0);

        $display("[TB] directed insertions");
        clearPlan();
        applyStimulus(0, 1'b0, 0, 12, 4);
        applyStimulus(0, 1'b1, 0, 2, 4);
        applyStimulus(1, 1'b0, 0, 6, 4);
        applyStimulus(1, 1'b1, 2, 9, 4);
        applyStimulus(0, 1'b1, 0, 80, 5);
        runPlan(1, cursor + 3);

        $display("[TB] reset during debounce");
        clearPlan();
        for (int t = 1; t <= 5; t++) raw5[t] = 1'b1;
        runPlan(1, 5);
        doReset(1'b1, 1'b0);
        clearPlan();
        applyStimulus(0, 1'b0, 0, 12, 4);
        runPlan(1, cursor + 3);

        $display("[TB] reset during jam");
        clearPlan();
        applyStimulus(0, 1'b1, 0, 80, 4);
        runPlan(1, 76);
        doReset(1'b0, 1'b1);
        clearPlan();
        applyStimulus(0, 1'b1, 0, 6, 4);
        runPlan(1, cursor + 3);

        $display("[TB] random insertions");
        clearPlan();
        for (int i = 0; i < 40; i++) begin
            int kind;
            int d;
            int len;
            int gap;
            bit lead10;
            kind   = int'($urandom_range(0, 1));
            lead10 = 1'($urandom_range(0, 1));
            d      = (kind == 1) ? int'($urandom_range(0, DEB - 1)) : 0;
            len    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 75)) : int'($urandom_range(1, 14));
            if (len <= d) len = d + 1;
            gap    = int'($urandom_range(3, 6));
            applyStimulus(kind, lead10, d, len, gap);
        end
        runPlan(1, cursor + 3);

`ifdef COIN_TOTAL_EN
        $display("[TB] total saturation");
        doReset(1'b0, 1'b0);
        clearPlan();
        emit26 = 0;
        for (int i = 0; i < 26; i++) begin
            if (i == 25) emit26 = cursor + 2 + DEB;
            applyStimulus(0, 1'b1, 0, 6, 3);
        end
        runPlan(1, emit26);
        checkVal("total_after_25", emit26, total, 8'd250);
        runPlan(emit26 + 1, cursor + 3);
        checkVal("total_after_26", cursor + 3, total, 8'd255);
`endif

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of stable cycles a sensor must be held before a coin is accepted (legal range 1..255).
REQ-002 Parameter JAM_CYCLES, default 64, is the number of cycles in RELEASE after which a coin is flagged as jammed (legal range 2..65535).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sense5  input  1  raw, asynchronous 5-unit coin sensor; high while a coin is present.
REQ-006 sense10  input  1  raw, asynchronous 10-unit coin sensor; high while a coin is present.
REQ-007 coin  output  2  registered coin code for the downstream vending FSM: 00 none, 01 five, 10 ten, one-cycle pulse per accepted coin; 11 is never driven.
REQ-008 reject  output  1  registered one-cycle pulse when an ambiguous (both-sensor) coin is detected.
REQ-009 jam  output  1  registered level, high while the block is in JAM.

Function
REQ-010 Each sensor SHALL pass through a 2-flop synchronizer; all decisions use only the synchronized values s5/s10.
REQ-011 States: IDLE, DEBOUNCE, EMIT, RELEASE, JAM; one 16-bit counter cnt is shared by DEBOUNCE and RELEASE and is cleared on every state entry.
REQ-012 IDLE: exactly one of s5/s10 high -> DEBOUNCE, latch which sensor; both high -> pulse reject, go to RELEASE; neither -> stay.
REQ-013 DEBOUNCE: latched sensor low -> IDLE with no output (glitch); other sensor high -> pulse reject, go to RELEASE; otherwise cnt++, and when cnt == DEBOUNCE_CYCLES-1 -> EMIT.
REQ-014 EMIT: coin SHALL equal the latched code for exactly that one cycle; unconditional next state RELEASE.
REQ-015 RELEASE: s5 and s10 both low -> IDLE; otherwise cnt++, and when cnt == JAM_CYCLES-1 -> JAM.
REQ-016 JAM: jam=1; s5 and s10 both low -> IDLE, and jam deasserts in the IDLE cycle.
REQ-017 Latency: with a sensor held clean, coin SHALL be nonzero during the cycle after clock edge DEBOUNCE_CYCLES+3, counting edge 1 as the first edge that samples the raw sensor high.
REQ-018 At most one coin pulse SHALL be produced per sensor assertion; a new coin requires both sensors low (return to IDLE) first.
REQ-019 coin SHALL be 00 in every state other than EMIT; reject and jam are never asserted in the same cycle as a nonzero coin.

Reset
REQ-020 While reset is high at a clock edge: the state goes to IDLE; synchronizers and cnt are cleared; coin=00, reject=0, jam=0.
REQ-021 Reset asserted mid-DEBOUNCE, mid-RELEASE or in JAM SHALL abort the operation with no coin or reject pulse emitted.
REQ-022 After reset deasserts, a sensor that is already high SHALL be treated as a new insertion.

Configuration
REQ-023 Macro COIN_TOTAL_EN: when defined, add the output total  output  8  running value inserted.
REQ-024 total adds 5 on each 01 pulse and 10 on each 10 pulse, saturates at 255, and is cleared by reset.
REQ-025 total updates in the cycle after the coin pulse.
REQ-026 Without COIN_TOTAL_EN, the total port and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-027 Defaults; sense5 high for 12 cycles from edge 1 -> coin=01 for exactly one cycle after edge 7, reject=0, jam=0; after the sensor drops, state returns to IDLE.
REQ-028 sense10 high for 2 cycles only -> coin stays 00 throughout, and no reject.
REQ-029 sense5 and sense10 rise together -> reject high for one cycle, coin stays 00; the block waits in RELEASE until both sensors are low.
REQ-030 sense10 held for 80 cycles -> one coin=10 pulse, then jam=1 64 cycles after EMIT; jam=0 one cycle after the synchronized sensor falls.
REQ-031 Reset pulsed during DEBOUNCE (cnt=2) with sense5 still high -> no pulse from the aborted attempt; a fresh coin=01 pulse follows DEBOUNCE_CYCLES+3 edges after reset release.
REQ-032 COIN_TOTAL_EN defined; 26 clean ten-unit coins -> total reads 250 after 25 coins and 255 (saturated) after the 26th.
